writeback_arbiter: RTL and testbench

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/constants_pkg.sv | 6 +
 rtl/structure_pkg.sv | 9 +
 rtl/writeback_arbiter_pkg.sv | 8 +
 rtl/writeback_arbiter_if.sv | 17 +
 rtl/wb_skid_fifo.sv | 50 +++++
 rtl/writeback_arbiter.sv | 49 ++++
 tb/tb_writeback_arbiter.sv | 124 ++++++++++++
 7 files changed

// File: rtl/constants_pkg.sv
// constants_pkg: architectural widths and writeback buffer sizing shared across the core.
package constants_pkg;
   localparam int ARCH_LEN     = 32;
   localparam int REG_IDX_W    = 5;
   localparam int WB_BUF_DEPTH = 2;
endpackage

// File: rtl/structure_pkg.sv
// structure_pkg: decoded-instruction record passed between pipeline stages.
package structure_pkg;
   import constants_pkg::*;
   typedef struct packed {
      logic                 valid;
      logic [REG_IDX_W-1:0] rd;
      logic [ARCH_LEN-1:0]  dst_reg_data;
   } inst_decoded_t;
endpackage

// File: rtl/writeback_arbiter_pkg.sv
// writeback_arbiter_pkg: retire-source select and register-file write qualification.
package writeback_arbiter_pkg;
   import structure_pkg::*;
   typedef enum logic [1:0] {SEL_ALU, SEL_MUL, SEL_HEAD} wb_sel_t;
   function automatic logic writes_rf(inst_decoded_t inst);
      return inst.valid && inst.rd != '0;
   endfunction
endpackage

// File: rtl/writeback_arbiter_if.sv
// writeback_arbiter_if: execution results in, stalls and register-file write port out.
interface writeback_arbiter_if;
   import constants_pkg::*;
   import structure_pkg::*;
   inst_decoded_t        inst_alu_in;
   inst_decoded_t        inst_mul_in;
   inst_decoded_t        inst_wb_out;
   logic                 stall_alu_out;
   logic                 stall_mul_out;
   logic                 rf_we;
   logic [REG_IDX_W-1:0] rf_waddr;
   logic [ARCH_LEN-1:0]  rf_wdata;
   modport master (output inst_alu_in, inst_mul_in,
                   input  inst_wb_out, stall_alu_out, stall_mul_out, rf_we, rf_waddr, rf_wdata);
   modport slave  (input  inst_alu_in, inst_mul_in,
                   output inst_wb_out, stall_alu_out, stall_mul_out, rf_we, rf_waddr, rf_wdata);
endinterface

// File: rtl/wb_skid_fifo.sv
// wb_skid_fifo: in-order ALU result buffer with per-entry destination-register match.
module wb_skid_fifo
   import constants_pkg::*;
   import structure_pkg::*;
#(
   parameter  int DEPTH = WB_BUF_DEPTH,
   localparam int PW    = DEPTH > 1 ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic                 pop,
   input  inst_decoded_t        push_data,
   input  logic [REG_IDX_W-1:0] cmp_rd,
   output inst_decoded_t        head,
   output logic [CW-1:0]        count,
   output logic [DEPTH-1:0]     rd_hit
);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
   inst_decoded_t    mem [DEPTH];
   logic [DEPTH-1:0] vld;
   logic [PW-1:0]    rptr, wptr;
   always_ff @(posedge clk) begin
      if (rst) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
         vld   <= '0;
      end else begin
         if (push) begin
            mem[wptr] <= push_data;
            vld[wptr] <= 1'b1;
            wptr      <= wptr == LAST ? '0 : wptr + 1'b1;
         end
         if (pop) begin
            vld[rptr] <= 1'b0;
            rptr      <= rptr == LAST ? '0 : rptr + 1'b1;
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end
   always_comb begin
      head       = mem[rptr];
      head.valid = vld[rptr];
   end
   for (genvar g = 0; g < DEPTH; g++) begin : g_hit
      assign rd_hit[g] = vld[g] && mem[g].rd == cmp_rd;
   end
endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges ALU and multiplier results onto one register-file write port,
// buffering ALU results so the multiplier pipeline is stalled only on full or RAW hazards.
module writeback_arbiter
   import structure_pkg::*;
   import writeback_arbiter_pkg::*;
#(
   parameter int WB_BUF_DEPTH = constants_pkg::WB_BUF_DEPTH
) (
   input logic                clk,
   input logic                rst,
   writeback_arbiter_if.slave wb
);
   localparam int CW = $clog2(WB_BUF_DEPTH + 1);
   logic [CW-1:0]           count;
   logic [WB_BUF_DEPTH-1:0] rd_hit;
   inst_decoded_t           head, win;
   logic                    full, hit, push, pop, stall_mul;
   wb_sel_t                 sel;
   wb_skid_fifo #(.DEPTH(WB_BUF_DEPTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .pop      (pop),
      .push_data(wb.inst_alu_in),
      .cmp_rd   (wb.inst_mul_in.rd),
      .head     (head),
      .count    (count),
      .rd_hit   (rd_hit)
   );
   assign full = count == CW'(WB_BUF_DEPTH);
   // An older buffered ALU write to the same rd must land before the multiplier's.
   assign hit  = wb.inst_mul_in.valid && wb.inst_mul_in.rd != '0 && |rd_hit;
   always_comb begin
      sel       = full || hit ? SEL_HEAD : wb.inst_mul_in.valid ? SEL_MUL : count != '0 ? SEL_HEAD : SEL_ALU;
      stall_mul = full ? wb.inst_mul_in.valid : hit;
      push      = !rst && !full && sel != SEL_ALU && wb.inst_alu_in.valid;
      pop       = !rst && sel == SEL_HEAD;
      win       = sel == SEL_HEAD ? head : sel == SEL_MUL ? wb.inst_mul_in : wb.inst_alu_in;
   end
   always_comb begin
      wb.inst_wb_out       = win;
      wb.inst_wb_out.valid = win.valid && !rst;
   end
   assign wb.stall_alu_out = !rst && full;
   assign wb.stall_mul_out = !rst && stall_mul;
   assign wb.rf_we         = !rst && writes_rf(win);
   assign wb.rf_waddr      = win.rd;
   assign wb.rf_wdata      = win.dst_reg_data;
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed scenarios then randomized traffic against a queue-based model.
module tb_writeback_arbiter;
   import constants_pkg::*;
   import structure_pkg::*;
   localparam int D = WB_BUF_DEPTH;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   writeback_arbiter_if bus ();
   writeback_arbiter #(.WB_BUF_DEPTH(D)) dut (.clk(clk), .rst(rst), .wb(bus));
   int passed = 0;
   int total  = 0;
   inst_decoded_t q[$];
   inst_decoded_t e_wb;
   logic e_sa, e_sm, m_pop, m_push;
   logic o_we, o_sa, o_sm, o_wbv;
   logic [REG_IDX_W-1:0] o_waddr;
   logic [ARCH_LEN-1:0]  o_wdata;
   logic [7:0]           o_cnt;
   inst_decoded_t idle;
   function automatic inst_decoded_t mk(logic v, int rd, int data);
      inst_decoded_t t;
      t.valid        = v;
      t.rd           = REG_IDX_W'(rd);
      t.dst_reg_data = ARCH_LEN'(data);
      return t;
   endfunction
   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask
   // Reference: the ALU buffer is a plain queue; each cycle picks one retiree by priority.
   task automatic model(inst_decoded_t a, inst_decoded_t m, logic r);
      bit hazard = 0;
      e_wb = '0; e_sa = 0; e_sm = 0; m_pop = 0; m_push = 0;
      if (!r) begin
         foreach (q[i]) if (m.valid && m.rd != 0 && q[i].rd == m.rd) hazard = 1;
         e_sa = q.size() == D;
         if (e_sa || hazard) begin
            e_wb = q[0]; e_sm = m.valid; m_pop = 1; m_push = !e_sa && a.valid;
         end else if (m.valid) begin
            e_wb = m; m_push = a.valid;
         end else if (q.size() > 0) begin
            e_wb = q[0]; m_pop = 1; m_push = a.valid;
         end else e_wb = a;
      end
   endtask
   task automatic step(inst_decoded_t a, inst_decoded_t m, logic r);
      @(negedge clk);
      rst = r;
      bus.inst_alu_in = a;
      bus.inst_mul_in = m;
      #1;
      o_we = bus.rf_we; o_sa = bus.stall_alu_out; o_sm = bus.stall_mul_out;
      o_wbv = bus.inst_wb_out.valid; o_waddr = bus.rf_waddr; o_wdata = bus.rf_wdata;
      o_cnt = 8'(dut.u_fifo.count);
      model(a, m, r);
      chk("stall_alu", o_sa, e_sa);
      chk("stall_mul", o_sm, e_sm);
      chk("wb_valid", o_wbv, e_wb.valid);
      chk("rf_we", o_we, e_wb.valid && e_wb.rd != 0);
      if (e_wb.valid) begin
         chk("wb_rd", bus.inst_wb_out.rd, e_wb.rd);
         chk("rf_waddr", o_waddr, e_wb.rd);
         chk("rf_wdata", o_wdata, e_wb.dst_reg_data);
      end
      @(posedge clk);
      if (r) q.delete();
      else begin
         if (m_pop) void'(q.pop_front());
         if (m_push) q.push_back(a);
      end
   endtask
   initial begin
      inst_decoded_t a, m;
      logic ha, hm, r;
      idle = mk(0, 0, 0);
      bus.inst_alu_in = idle;
      bus.inst_mul_in = idle;
      step(mk(1, 5, 1), mk(1, 6, 2), 1);
      chk("rst_we", o_we, 0); chk("rst_sa", o_sa, 0); chk("rst_sm", o_sm, 0); chk("rst_wbv", o_wbv, 0);
      step(mk(1, 5, 'h11), idle, 0);
      chk("byp_we", o_we, 1); chk("byp_waddr", o_waddr, 5); chk("byp_wdata", o_wdata, 'h11);
      step(mk(1, 4, 'h44), mk(1, 3, 'h33), 0);
      chk("byp_cnt", o_cnt, 0); chk("dual_waddr0", o_waddr, 3); chk("dual_sm0", o_sm, 0);
      step(idle, idle, 0);
      chk("dual_waddr1", o_waddr, 4); chk("dual_wdata1", o_wdata, 'h44); chk("dual_sm1", o_sm, 0);
      step(mk(1, 20, 20), mk(1, 10, 10), 0);
      step(mk(1, 21, 21), mk(1, 11, 11), 0);
      step(mk(1, 22, 22), mk(1, 12, 12), 0);
      chk("full_sa", o_sa, 1); chk("full_sm", o_sm, 1); chk("full_waddr", o_waddr, 20);
      step(mk(1, 22, 22), mk(1, 12, 12), 0);
      chk("full_next_waddr", o_waddr, 12); chk("full_next_sa", o_sa, 0);
      step(idle, mk(1, 13, 13), 0);
      step(idle, mk(1, 13, 13), 0);
      step(idle, idle, 0);
      step(idle, idle, 0);
      step(mk(1, 7, 'h77), mk(1, 2, 'h22), 0);
      step(idle, mk(1, 7, 'h99), 0);
      chk("raw_waddr", o_waddr, 7); chk("raw_wdata", o_wdata, 'h77); chk("raw_sm", o_sm, 1);
      step(idle, mk(1, 7, 'h99), 0);
      chk("raw_mul_wdata", o_wdata, 'h99); chk("raw_mul_sm", o_sm, 0);
      step(mk(1, 0, 'hFF), idle, 0);
      chk("rd0_we", o_we, 0); chk("rd0_wbv", o_wbv, 1);
      step(mk(1, 8, 1), mk(1, 9, 2), 0);
      step(mk(1, 10, 3), mk(1, 11, 4), 0);
      step(mk(1, 12, 5), idle, 1);
      chk("rstfull_we", o_we, 0); chk("rstfull_sa", o_sa, 0); chk("rstfull_sm", o_sm, 0);
      step(idle, idle, 0);
      chk("post_rst_cnt", o_cnt, 0); chk("post_rst_we", o_we, 0); chk("post_rst_sa", o_sa, 0);
      a = idle; m = idle; ha = 0; hm = 0;
      for (int i = 0; i < 600; i++) begin
         if (!ha) a = mk($urandom_range(0, 2) != 0, $urandom_range(0, 7), $urandom);
         if (!hm) m = mk($urandom_range(0, 1), $urandom_range(0, 7), $urandom);
         r = $urandom_range(0, 49) == 0;
         step(a, m, r);
         ha = e_sa;
         hm = e_sm;
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
